dff_universal_shift_reg: RTL and testbench
==========================================

// Module: dff_universal_shift_reg
// PURPOSE
//   Parametrised N-bit universal register built on positive-edge D flip-flop semantics.
//   Per-clock operating modes: hold, shift right, shift left, parallel load.
//   Optional rotate (wrap-around) in place of the serial inputs; complementary Qn bus.
//   Serves as the general register / serialiser / deserialiser primitive in the datapath
//   (above the single-bit flop level).
// PARAMETERS
//   WIDTH      8    number of register bits (>=2)
//   RESET_VAL  0    value loaded into Q on reset (WIDTH bits, zero-extended/truncated)
// PORTS
//   clk        in   1      clock; all state changes on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      clock enable; 0 forces hold regardless of mode
//   mode       in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   rot        in   1      1: shifts wrap around internally; serial inputs ignored
//   ser_in_r   in   1      serial input into MSB during shift right (rot=0)
//   ser_in_l   in   1      serial input into LSB during shift left (rot=0)
//   D          in   WIDTH  parallel load data
//   Q          out  WIDTH  register contents
//   Qn         out  WIDTH  bitwise complement of Q, always ~Q (no extra latency)
//   ser_out_r  out  1      Q[0]  (bit shifted out on shift right)
//   ser_out_l  out  1      Q[WIDTH-1] (bit shifted out on shift left)
// BEHAVIOUR
//   Reset:  rst_n=0 asynchronously forces Q=RESET_VAL, Qn=~RESET_VAL,
//           ser_out_r=RESET_VAL[0], ser_out_l=RESET_VAL[WIDTH-1]; held while low.
//           Deassertion takes effect at the first rising edge with rst_n=1; no glitch on Q.
//           Reset mid-shift discards the in-flight operation; no partial update.
//   Latency: one cycle; inputs sampled at rising edge, Q valid after that edge.
//   Next state when en=1 (Q' = value after the edge):
//     00 hold:    Q' = Q
//     01 right:   Q' = {rot ? Q[0] : ser_in_r, Q[WIDTH-1:1]}
//     10 left:    Q' = {Q[WIDTH-2:0], rot ? Q[WIDTH-1] : ser_in_l}
//     11 load:    Q' = D  (rot, ser_in_* ignored)
//   en=0: Q' = Q for every mode/rot combination.
//   Qn, ser_out_r, ser_out_l are combinational functions of Q only; they never depend on
//   the current inputs.
//   Rotate: WIDTH consecutive rotates in the same direction return the original value.
//   Shift: WIDTH consecutive non-rotating shifts fully replace the contents with serial data.
//   X/Z on mode with en=1 is illegal; the bench asserts mode is known whenever en=1.
//   Fully synchronous datapath: no latches and no combinational path from any input to
//   any output.
// TESTING
//   Reset: WIDTH=8, RESET_VAL=8'hA5; pulse rst_n low mid-cycle.
//     -> Q=A5, Qn=5A immediately, without waiting for a clock edge.
//   Load and hold: en=1, mode=11, D=3C, then mode=00 for 3 cycles.
//     -> Q=3C on the cycle after load, unchanged for 3 cycles.
//   Shift right with serial input: Q=81, mode=01, rot=0, ser_in_r=1.
//     -> C0, then E0 (ser_out_r: 1, then 0, then 0).
//   Rotate left: Q=81, mode=10, rot=1, 8 cycles.
//     -> 03, 06, 0C, ..., back to 81 on the 8th edge.
//   Enable gating: Q=F0, en=0, mode=11, D=00 for 2 cycles.
//     -> Q stays F0; raise en -> Q=00 on the next edge.
//   Reset mid-operation: rotating pattern, rst_n low between edges.
//     -> Q=RESET_VAL at once; the first edge after release performs the commanded mode
//        starting from RESET_VAL.

Source files
------------

// File: rtl/dff_universal_shift_reg.sv
// N-bit universal register: hold / shift right / shift left / parallel load,
// with optional rotate and a complementary output bus.
module dff_universal_shift_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             ser_out_r,
    output logic             ser_out_l
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             fill_msb;
    logic             fill_lsb;

    // Rotate feeds the bit leaving the opposite end back in place of serial input.
    always_comb begin
        q_nxt    = q_r;
        fill_msb = rot ? q_r[0]       : ser_in_r;
        fill_lsb = rot ? q_r[WIDTH-1] : ser_in_l;
        if (en) begin
            case (mode_e'(mode))
                MODE_HOLD:  q_nxt = q_r;
                MODE_RIGHT: q_nxt = {fill_msb, q_r[WIDTH-1:1]};
                MODE_LEFT:  q_nxt = {q_r[WIDTH-2:0], fill_lsb};
                MODE_LOAD:  q_nxt = D;
                default:    q_nxt = q_r;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RESET_VAL;
        end else begin
            q_r <= q_nxt;
        end
    end

    assign Q         = q_r;
    assign Qn        = ~q_r;
    assign ser_out_r = q_r[0];
    assign ser_out_l = q_r[WIDTH-1];

endmodule

// File: tb/tb_dff_universal_shift_reg.sv
// Directed bench for dff_universal_shift_reg (WIDTH=8, RESET_VAL=A5).
module tb_dff_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       rot = 1'b0;
    logic       ser_in_r = 1'b0;
    logic       ser_in_l = 1'b0;
    logic [7:0] D = 8'h00;
    logic [7:0] Q;
    logic [7:0] Qn;
    logic       ser_out_r;
    logic       ser_out_l;

    int unsigned total = 0;
    int unsigned bad   = 0;

    dff_universal_shift_reg #(
        .WIDTH    (8),
        .RESET_VAL(8'hA5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .rot      (rot),
        .ser_in_r (ser_in_r),
        .ser_in_l (ser_in_l),
        .D        (D),
        .Q        (Q),
        .Qn       (Qn),
        .ser_out_r(ser_out_r),
        .ser_out_l(ser_out_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && en) begin
            assert (!$isunknown(mode)) else $error("mode unknown while enabled");
        end
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        en   = 1'b1;
        mode = 2'b11;
        D    = val;
        step();
    endtask

    logic [7:0] rotl_exp [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    logic       ser_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        // Asynchronous reset asserted between edges.
        #2 rst_n = 1'b0;
        #1;
        check("rst_q", Q, 8'hA5);
        check("rst_qn", Qn, 8'h5A);
        check("rst_sor", {7'd0, ser_out_r}, 8'h01);
        check("rst_sol", {7'd0, ser_out_l}, 8'h01);
        en = 1'b1; mode = 2'b11; D = 8'hFF;
        step();
        check("rst_held", Q, 8'hA5);
        rst_n = 1'b1;

        // Load then hold.
        load(8'h3C);
        check("load", Q, 8'h3C);
        check("load_qn", Qn, 8'hC3);
        mode = 2'b00; D = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold", Q, 8'h3C);
        end

        // Shift right with serial input.
        load(8'h81);
        check("sr_so0", {7'd0, ser_out_r}, 8'h01);
        mode = 2'b01; rot = 1'b0; ser_in_r = 1'b1;
        step();
        check("sr1", Q, 8'hC0);
        check("sr_so1", {7'd0, ser_out_r}, 8'h00);
        step();
        check("sr2", Q, 8'hE0);
        check("sr_so2", {7'd0, ser_out_r}, 8'h00);

        // Shift left with serial input.
        load(8'h81);
        check("sl_so0", {7'd0, ser_out_l}, 8'h01);
        mode = 2'b10; rot = 1'b0; ser_in_l = 1'b0;
        step();
        check("sl1", Q, 8'h02);
        ser_in_l = 1'b1;
        step();
        check("sl2", Q, 8'h05);
        check("sl_so2", {7'd0, ser_out_l}, 8'h00);

        // Rotate right ignores serial input.
        load(8'h81);
        mode = 2'b01; rot = 1'b1; ser_in_r = 1'b0;
        step();
        check("rr1", Q, 8'hC0);
        step();
        check("rr2", Q, 8'h60);

        // Rotate left eight times returns the original.
        load(8'h81);
        mode = 2'b10; rot = 1'b1; ser_in_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rotl", Q, rotl_exp[i]);
        end

        // Eight plain shifts fully replace the contents.
        load(8'h81);
        mode = 2'b01; rot = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ser_in_r = ser_bits[i];
            step();
        end
        check("sr_fill", Q, 8'h4D);

        // Enable gating.
        load(8'hF0);
        en = 1'b0; mode = 2'b11; D = 8'h00;
        step();
        check("en0_a", Q, 8'hF0);
        step();
        check("en0_b", Q, 8'hF0);
        mode = 2'b01; rot = 1'b1;
        step();
        check("en0_rot", Q, 8'hF0);
        en = 1'b1; mode = 2'b11; rot = 1'b0;
        step();
        check("en1_load", Q, 8'h00);

        // Load ignores rot and serial inputs.
        rot = 1'b1; ser_in_r = 1'b1; ser_in_l = 1'b1;
        load(8'h5A);
        check("load_rot", Q, 8'h5A);

        // Reset in the middle of a rotate sequence.
        rot = 1'b0; ser_in_r = 1'b0; ser_in_l = 1'b0;
        load(8'h81);
        mode = 2'b10; rot = 1'b1;
        step();
        check("mid_rot", Q, 8'h03);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst", Q, 8'hA5);
        check("mid_rst_qn", Qn, 8'h5A);
        step();
        check("mid_rst_held", Q, 8'hA5);
        rst_n = 1'b1;
        step();
        check("post_rst_rot", Q, 8'h4B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
